// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port main-memory block arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_t;

    localparam int DEFAULT_BEATS = 4;
    localparam int BLOCK_OFF_W   = $clog2(DEFAULT_BEATS) + 2;
    localparam int PORT_TLB      = 0;
    localparam int PORT_CACHE    = 1;

    // Byte-offset width of one block for an arbitrary beat count.
    function automatic int block_off_w(input int beats);
        return $clog2(beats) + 2;
    endfunction

endpackage

// File: rtl/pulse_sync_edge.sv
// Two-flop synchronizer for an asynchronous pulse followed by a rising-edge
// detector; emits a single-cycle event per incoming pulse.
module pulse_sync_edge (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_async,
    output logic o_pulse
);

    logic r_sync1;
    logic r_sync2;
    logic r_sync2_d;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_sync2_d <= 1'b0;
        end else begin
            r_sync1   <= i_async;
            r_sync2   <= r_sync1;
            r_sync2_d <= r_sync2;
        end
    end

    assign o_pulse = r_sync2 & ~r_sync2_d;

endmodule

// File: rtl/mem_block_arbiter.sv
// Arbitrates the TLB walker (port 0) and data cache (port 1) onto a
// single-ported main memory, moving one block as BEATS single-word beats.
module mem_block_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int WORD_W = 32,
    parameter int BEATS  = 4,
    parameter bit RR_EN  = 1'b1
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic [1:0]                i_req_valid,
    input  logic [1:0]                i_req_write,
    input  logic [ADDR_W-1:0]         i_req0_addr,
    input  logic [ADDR_W-1:0]         i_req1_addr,
    input  logic [BEATS*WORD_W-1:0]   i_req0_wdata,
    input  logic [BEATS*WORD_W-1:0]   i_req1_wdata,
    output logic [1:0]                o_req_accept,
    output logic [1:0]                o_resp_valid,
    output logic [BEATS*WORD_W-1:0]   o_resp_rdata,
    output logic                      o_mem_read_or_write,
    output logic [ADDR_W-1:0]         o_mem_address,
    output logic [WORD_W-1:0]         o_mem_write_data,
    input  logic                      i_mem_done,
    input  logic [WORD_W-1:0]         i_mem_read_data
);

    localparam int OFF_W  = block_off_w(BEATS);
    localparam int BEAT_W = $clog2(BEATS);
    localparam int HI_W   = ADDR_W - OFF_W;

    arb_state_t                 r_state;
    arb_state_t                 w_state_next;
    logic [BEAT_W-1:0]          r_beat;
    logic                       r_port;
    logic                       r_write;
    logic                       r_rr_ptr;
    logic [HI_W-1:0]            r_addr_hi;
    logic [BEATS*WORD_W-1:0]    r_wdata;
    logic [BEATS*WORD_W-1:0]    r_rdata;
    logic [BEATS*WORD_W-1:0]    w_block;
    logic [WORD_W-1:0]          r_slot [BEATS-1];
    logic [1:0]                 r_req_accept;
    logic [1:0]                 r_resp_valid;
    logic                       w_done_evt;
    logic                       w_grant;
    logic                       w_capture;
    logic                       w_last;
    logic                       w_winner;
    logic                       w_unused_offset;

    // Block offset bits select nothing: the beat counter supplies them.
    assign w_unused_offset = ^{i_req0_addr[OFF_W-1:0], i_req1_addr[OFF_W-1:0]};

    pulse_sync_edge u_done_sync (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_async (i_mem_done),
        .o_pulse (w_done_evt)
    );

    always_comb begin
        w_winner = 1'(PORT_TLB);
        if (i_req_valid == 2'b11) begin
            w_winner = RR_EN ? r_rr_ptr : 1'(PORT_TLB);
        end else if (i_req_valid[PORT_CACHE]) begin
            w_winner = 1'(PORT_CACHE);
        end
    end

    assign w_last = (r_beat == BEAT_W'(BEATS - 1));

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_grant      = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|i_req_valid) begin
                    w_grant      = 1'b1;
                    w_state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (w_done_evt) begin
                    w_capture    = 1'b1;
                    w_state_next = w_last ? ST_RESP : ST_ISSUE;
                end
            end
            ST_RESP: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_beat       <= '0;
            r_port       <= 1'b0;
            r_write      <= 1'b0;
            r_rr_ptr     <= 1'(PORT_TLB);
            r_addr_hi    <= '0;
            r_wdata      <= '0;
            r_rdata      <= '0;
            r_req_accept <= '0;
            r_resp_valid <= '0;
        end else begin
            r_req_accept <= '0;
            r_resp_valid <= '0;
            if (w_grant) begin
                r_port                 <= w_winner;
                r_write                <= i_req_write[w_winner];
                r_addr_hi              <= w_winner ? i_req1_addr[ADDR_W-1:OFF_W]
                                                   : i_req0_addr[ADDR_W-1:OFF_W];
                r_wdata                <= w_winner ? i_req1_wdata : i_req0_wdata;
                r_req_accept[w_winner] <= 1'b1;
                if (RR_EN) begin
                    r_rr_ptr <= ~w_winner;
                end
            end
            if (w_capture) begin
                if (w_last) begin
                    r_resp_valid[r_port] <= 1'b1;
                    // Publish the block only once it is complete so a reader
                    // never sees a half-refilled mix of old and new words.
                    if (!r_write) begin
                        r_rdata <= w_block;
                    end
                end else begin
                    r_beat <= r_beat + 1'b1;
                end
            end
            if (r_state == ST_RESP) begin
                r_beat <= '0;
            end
        end
    end

    // The final beat is forwarded straight from memory into the block.
    for (genvar gi = 0; gi < BEATS; gi++) begin : g_slot
        if (gi < BEATS - 1) begin : g_held
            always_ff @(posedge i_clock or posedge i_reset) begin
                if (i_reset) begin
                    r_slot[gi] <= '0;
                end else if (w_capture && !r_write && (r_beat == BEAT_W'(gi))) begin
                    r_slot[gi] <= i_mem_read_data;
                end
            end
            assign w_block[gi*WORD_W +: WORD_W] = r_slot[gi];
        end else begin : g_last
            assign w_block[gi*WORD_W +: WORD_W] = i_mem_read_data;
        end
    end

    assign o_req_accept        = r_req_accept;
    assign o_resp_valid        = r_resp_valid;
    assign o_resp_rdata        = r_rdata;
    assign o_mem_read_or_write = r_write && ((r_state == ST_ISSUE) || (r_state == ST_WAIT));
    assign o_mem_address       = {r_addr_hi, r_beat, 2'b00};
    assign o_mem_write_data    = r_wdata[r_beat*WORD_W +: WORD_W];

endmodule

// File: tb/tb_mem_block_arbiter.sv
// Self-checking bench for mem_block_arbiter: a responding memory, a
// reference word array, and one task per scenario.
module tb_mem_block_arbiter;

    localparam int AW = 10;
    localparam int WW = 32;
    localparam int NB = 4;
    localparam int BW = NB * WW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    req_valid = 2'b00;
    logic [1:0]    req_write = 2'b00;
    logic [AW-1:0] a0 = '0;
    logic [AW-1:0] a1 = '0;
    logic [BW-1:0] wd0 = '0;
    logic [BW-1:0] wd1 = '0;
    logic [1:0]    acc;
    logic [1:0]    rv;
    logic [BW-1:0] rdata;
    logic          mrw;
    logic [AW-1:0] maddr;
    logic [WW-1:0] mwd;
    logic          mdone = 1'b0;
    logic [WW-1:0] mrdata = '0;

    logic [1:0]    fp_req_valid = 2'b00;
    logic [1:0]    fp_acc;
    logic [1:0]    fp_rv;
    logic [BW-1:0] fp_rdata;
    logic          fp_mrw;
    logic [AW-1:0] fp_maddr;
    logic [WW-1:0] fp_mwd;
    logic          fp_done = 1'b0;

    int errors = 0;
    int checks = 0;
    int last_served = 1;

    logic [WW-1:0] dev_mem [256];
    logic [WW-1:0] ref_mem [256];

    always #5 clk = ~clk;

    mem_block_arbiter #(.ADDR_W(AW), .WORD_W(WW), .BEATS(NB), .RR_EN(1'b1)) dut (
        .i_clock             (clk),
        .i_reset             (rst),
        .i_req_valid         (req_valid),
        .i_req_write         (req_write),
        .i_req0_addr         (a0),
        .i_req1_addr         (a1),
        .i_req0_wdata        (wd0),
        .i_req1_wdata        (wd1),
        .o_req_accept        (acc),
        .o_resp_valid        (rv),
        .o_resp_rdata        (rdata),
        .o_mem_read_or_write (mrw),
        .o_mem_address       (maddr),
        .o_mem_write_data    (mwd),
        .i_mem_done          (mdone),
        .i_mem_read_data     (mrdata)
    );

    mem_block_arbiter #(.ADDR_W(AW), .WORD_W(WW), .BEATS(NB), .RR_EN(1'b0)) dut_fp (
        .i_clock             (clk),
        .i_reset             (rst),
        .i_req_valid         (fp_req_valid),
        .i_req_write         (2'b00),
        .i_req0_addr         (10'h000),
        .i_req1_addr         (10'h010),
        .i_req0_wdata        ({BW{1'b0}}),
        .i_req1_wdata        ({BW{1'b0}}),
        .o_req_accept        (fp_acc),
        .o_resp_valid        (fp_rv),
        .o_resp_rdata        (fp_rdata),
        .o_mem_read_or_write (fp_mrw),
        .o_mem_address       (fp_maddr),
        .o_mem_write_data    (fp_mwd),
        .i_mem_done          (fp_done),
        .i_mem_read_data     (32'h0)
    );

    // Free-running done pulses for the fixed-priority instance.
    always begin
        repeat (6) @(negedge clk);
        fp_done = 1'b1;
        repeat (2) @(negedge clk);
        fp_done = 1'b0;
    end

    function automatic logic [1:0] onehot(input int p);
        return (p == 0) ? 2'b01 : 2'b10;
    endfunction

    function automatic logic [BW-1:0] ref_block(input logic [AW-1:0] base);
        logic [BW-1:0] blk;
        for (int i = 0; i < NB; i++) begin
            blk[i*WW +: WW] = ref_mem[int'(base[AW-1:2]) + i];
        end
        return blk;
    endfunction

    task automatic wait_accept(output logic [1:0] got);
        got = 2'b00;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (acc !== 2'b00) begin
                got = acc;
                break;
            end
        end
    endtask

    // Memory device: answers each beat after a random delay; returns early
    // (still in WAIT) when stop_beat is reached.
    task automatic serve_block(input logic [AW-1:0] base, input logic wr,
                               input logic [BW-1:0] wd, input int stop_beat,
                               output logic [1:0] rv_seen, output logic [BW-1:0] rd_seen,
                               output logic mrw_at_resp);
        logic [AW-1:0] exp_a;
        rv_seen = 2'b00;
        rd_seen = '0;
        mrw_at_resp = 1'b0;
        for (int b = 0; b < NB; b++) begin
            repeat ($urandom_range(2, 5)) @(negedge clk);
            exp_a = base + AW'(b * 4);
            checks++;
            if (maddr !== exp_a || mrw !== wr || (wr && mwd !== wd[b*WW +: WW])) begin
                errors++;
                $display("FAIL beat%0d: addr=%h rw=%b wdata=%h, expected addr=%h rw=%b wdata=%h",
                         b, maddr, mrw, mwd, exp_a, wr, wd[b*WW +: WW]);
            end
            if (b == stop_beat) return;
            if (mrw) dev_mem[maddr[AW-1:2]] = mwd;
            mrdata = dev_mem[maddr[AW-1:2]];
            mdone = 1'b1;
            for (int k = 0; k < 8; k++) begin
                @(negedge clk);
                if (k == 1) mdone = 1'b0;
                if (rv !== 2'b00) begin
                    rv_seen = rv;
                    rd_seen = rdata;
                    mrw_at_resp = mrw;
                    break;
                end
            end
            mdone = 1'b0;
            if (rv_seen !== 2'b00) break;
        end
    endtask

    task automatic do_transfer(input int p, input logic wr, input logic [AW-1:0] addr,
                               input logic [BW-1:0] wd, input string name,
                               output logic [BW-1:0] rd);
        logic [1:0]    got;
        logic [1:0]    rvs;
        logic          mrw_r;
        logic [AW-1:0] base;
        logic [BW-1:0] exp_rd;
        base = {addr[AW-1:4], 4'b0000};
        exp_rd = ref_block(base);
        req_write[p] = wr;
        if (p == 0) begin a0 = addr; wd0 = wd; end
        else        begin a1 = addr; wd1 = wd; end
        req_valid[p] = 1'b1;
        wait_accept(got);
        req_valid[p] = 1'b0;
        checks++;
        if (got !== onehot(p)) begin
            errors++;
            $display("FAIL %s accept: got=%b expected=%b", name, got, onehot(p));
        end
        serve_block(base, wr, wd, 99, rvs, rd, mrw_r);
        checks++;
        if (rvs !== onehot(p) || mrw_r !== 1'b0) begin
            errors++;
            $display("FAIL %s resp: resp_valid=%b rw=%b expected resp_valid=%b rw=0",
                     name, rvs, mrw_r, onehot(p));
        end
        if (!wr) begin
            checks++;
            if (rd !== exp_rd) begin
                errors++;
                $display("FAIL %s rdata: got=%h expected=%h", name, rd, exp_rd);
            end
        end else begin
            for (int i = 0; i < NB; i++) ref_mem[int'(base[AW-1:2]) + i] = wd[i*WW +: WW];
        end
        last_served = p;
        $display("xfer %s port=%0d %s addr=%h resp=%b data=%h", name, p, wr ? "W" : "R", addr, rvs, rd);
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({acc, rv, rdata, mrw, maddr, mwd} !== '0) begin
            errors++;
            $display("FAIL reset_hold: outputs=%h expected all zero", {acc, rv, rdata, mrw, maddr, mwd});
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({acc, rv, rdata, mrw, maddr, mwd} !== '0) begin
            errors++;
            $display("FAIL reset_release: outputs=%h expected all zero", {acc, rv, rdata, mrw, maddr, mwd});
        end
        $display("reset checked");
    endtask

    task automatic test_read_port1();
        logic [BW-1:0] rd;
        do_transfer(1, 1'b0, 10'h100, '0, "read_p1", rd);
        checks++;
        if (rd !== 128'h11111111_22222222_33333333_44444444) begin
            errors++;
            $display("FAIL read_p1_const: got=%h expected=%h", rd, 128'h11111111_22222222_33333333_44444444);
        end
    endtask

    task automatic test_unaligned_port0();
        logic [BW-1:0] rd;
        do_transfer(0, 1'b0, 10'h10C, '0, "unaligned_p0", rd);
        checks++;
        if (rd !== 128'h11111111_22222222_33333333_44444444) begin
            errors++;
            $display("FAIL unaligned_const: got=%h expected=%h", rd, 128'h11111111_22222222_33333333_44444444);
        end
    endtask

    task automatic test_write_readback();
        logic [BW-1:0] rd;
        logic [BW-1:0] blk;
        blk = {32'hD, 32'hC, 32'hB, 32'hA};
        do_transfer(1, 1'b1, 10'h200, blk, "write_p1", rd);
        do_transfer(1, 1'b0, 10'h200, '0, "readback_p1", rd);
        checks++;
        if (rd !== blk) begin
            errors++;
            $display("FAIL readback_const: got=%h expected=%h", rd, blk);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0]    got;
        logic [1:0]    rvs;
        logic          mrw_r;
        logic [BW-1:0] rd;
        logic [AW-1:0] base;
        int            p;
        int            exp_p;
        a0 = 10'h300 | AW'($urandom_range(0, 15) * 16);
        a1 = 10'h300 | AW'($urandom_range(0, 15) * 16);
        req_write = 2'b00;
        req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            exp_p = 1 - last_served;
            wait_accept(got);
            if (i == 3) req_valid = 2'b00;
            checks++;
            if (got !== onehot(exp_p)) begin
                errors++;
                $display("FAIL rr_grant%0d: got=%b expected=%b", i, got, onehot(exp_p));
            end
            p = got[1] ? 1 : 0;
            base = (p == 0) ? {a0[AW-1:4], 4'b0} : {a1[AW-1:4], 4'b0};
            serve_block(base, 1'b0, '0, 99, rvs, rd, mrw_r);
            checks++;
            if (rvs !== onehot(p) || rd !== ref_block(base)) begin
                errors++;
                $display("FAIL rr_resp%0d: resp_valid=%b data=%h expected resp_valid=%b data=%h",
                         i, rvs, rd, onehot(p), ref_block(base));
            end
            last_served = p;
            $display("rr grant %0d port=%0d addr=%h data=%h", i, p, base, rd);
        end
    endtask

    task automatic test_fixed_priority();
        logic [1:0] acc_q [$];
        logic [1:0] rv_q [$];
        logic [1:0] a_first, a_second, r_first, r_second;
        fp_req_valid = 2'b11;
        for (int n = 0; n < 400 && rv_q.size() < 2; n++) begin
            @(negedge clk);
            if (fp_acc !== 2'b00) begin
                acc_q.push_back(fp_acc);
                fp_req_valid = fp_req_valid & ~fp_acc;
            end
            if (fp_rv !== 2'b00) rv_q.push_back(fp_rv);
        end
        fp_req_valid = 2'b00;
        a_first  = (acc_q.size() > 0) ? acc_q[0] : 2'b00;
        a_second = (acc_q.size() > 1) ? acc_q[1] : 2'b00;
        r_first  = (rv_q.size() > 0) ? rv_q[0] : 2'b00;
        r_second = (rv_q.size() > 1) ? rv_q[1] : 2'b00;
        checks++;
        if (acc_q.size() != 2 || a_first !== 2'b01 || a_second !== 2'b10) begin
            errors++;
            $display("FAIL fixed_accept: count=%0d order=%b,%b expected 2 order=01,10",
                     acc_q.size(), a_first, a_second);
        end
        checks++;
        if (rv_q.size() != 2 || r_first !== 2'b01 || r_second !== 2'b10) begin
            errors++;
            $display("FAIL fixed_resp: count=%0d order=%b,%b expected 2 order=01,10",
                     rv_q.size(), r_first, r_second);
        end
        $display("fixed priority accept=%b,%b resp=%b,%b", a_first, a_second, r_first, r_second);
    endtask

    task automatic test_random();
        logic [BW-1:0] rd;
        logic [BW-1:0] wd;
        int            p;
        logic          wr;
        logic [AW-1:0] addr;
        for (int i = 0; i < 8; i++) begin
            p    = int'($urandom_range(0, 1));
            wr   = 1'($urandom_range(0, 1));
            addr = 10'h300 | AW'($urandom_range(0, 255));
            wd   = {$urandom, $urandom, $urandom, $urandom};
            do_transfer(p, wr, addr, wd, "random", rd);
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0]    got;
        logic [1:0]    rvs;
        logic          mrw_r;
        logic [BW-1:0] rd;
        logic          saw_resp;
        a1 = 10'h080;
        req_write[1] = 1'b0;
        req_valid[1] = 1'b1;
        wait_accept(got);
        req_valid[1] = 1'b0;
        serve_block(10'h080, 1'b0, '0, 2, rvs, rd, mrw_r);
        #2;
        rst = 1'b1;
        mdone = 1'b1;
        #1;
        checks++;
        if ({acc, rv, rdata, mrw, maddr, mwd} !== '0) begin
            errors++;
            $display("FAIL reset_mid_async: outputs=%h expected all zero", {acc, rv, rdata, mrw, maddr, mwd});
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        last_served = 1;
        saw_resp = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (k == 3) mdone = 1'b0;
            if (rv !== 2'b00 || acc !== 2'b00 || mrw !== 1'b0) saw_resp = 1'b1;
        end
        checks++;
        if (saw_resp) begin
            errors++;
            $display("FAIL reset_mid_quiet: activity after reset, expected none");
        end
        do_transfer(0, 1'b0, 10'h040, '0, "after_reset", rd);
        checks++;
        if (rd !== 128'hBBBBBBBB_55555555_EEEEEEEE_CCCCCCCC) begin
            errors++;
            $display("FAIL after_reset_const: got=%h expected=%h", rd, 128'hBBBBBBBB_55555555_EEEEEEEE_CCCCCCCC);
        end
    endtask

    initial begin
        logic [WW-1:0] v;
        for (int i = 0; i < 256; i++) begin
            v = $urandom;
            dev_mem[i] = v;
            ref_mem[i] = v;
        end
        dev_mem[64] = 32'h44444444; ref_mem[64] = 32'h44444444;
        dev_mem[65] = 32'h33333333; ref_mem[65] = 32'h33333333;
        dev_mem[66] = 32'h22222222; ref_mem[66] = 32'h22222222;
        dev_mem[67] = 32'h11111111; ref_mem[67] = 32'h11111111;
        dev_mem[16] = 32'hCCCCCCCC; ref_mem[16] = 32'hCCCCCCCC;
        dev_mem[17] = 32'hEEEEEEEE; ref_mem[17] = 32'hEEEEEEEE;
        dev_mem[18] = 32'h55555555; ref_mem[18] = 32'h55555555;
        dev_mem[19] = 32'hBBBBBBBB; ref_mem[19] = 32'hBBBBBBBB;

        test_reset();
        test_read_port1();
        test_unaligned_port0();
        test_write_readback();
        test_round_robin();
        test_fixed_priority();
        test_random();
        test_reset_mid();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_block_arbiter.md
Name: mem_block_arbiter

Overview:
- Sits between two block requesters and the single-ported main memory: port 0 is the TLB page-table walker, port 1 is the data cache refill/write-back path.
- Grants one requester at a time.
- Sequences one 4-word block transfer as four single-word memory beats, each completed by a memory done pulse.
- Returns the whole block, or acknowledges the write, with a one-cycle response pulse.

Parameters:
- ADDR_W, 10, byte address width of main memory.
- WORD_W, 32, memory word width.
- BEATS, 4, words per block; must be a power of two.
- RR_EN, 1, 1 = round-robin arbitration, 0 = fixed priority with port 0 winning.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  2  per-port request; held until req_accept.
- req_write  in  2  per-port: 1 = block write, 0 = block read.
- req0_addr / req1_addr  in  ADDR_W each  block byte address; low log2(BEATS)+2 bits are ignored.
- req0_wdata / req1_wdata  in  BEATS*WORD_W each  write block; beat i is at [WORD_W*i +: WORD_W].
- req_accept  out  2  one-cycle pulse when that port's request is latched.
- resp_valid  out  2  one-cycle pulse when that port's transfer completes.
- resp_rdata  out  BEATS*WORD_W  read block, same packing as wdata; valid while resp_valid is high.
- mem_read_or_write  out  1  1 = write, 0 = read.
- mem_address  out  ADDR_W  beat byte address.
- mem_write_data  out  WORD_W  beat write word.
- mem_done  in  1  per-beat completion pulse; asynchronous to clock.
- mem_read_data  in  WORD_W  read word; valid at the mem_done pulse.

Behaviour:
- Reset values: state IDLE, all outputs 0, beat counter 0, rr pointer = port 0, captured data 0.
- mem_done handling: passes through a 2-flop synchronizer, then a rising-edge detect produces done_evt (one cycle).
- mem_read_data: sampled into the beat slot on the cycle done_evt is asserted; memory holds it stable for ≥2 time units after done.
- IDLE:
  - If any req_valid is set, pick the winner.
  - RR_EN=0: port 0 wins.
  - RR_EN=1: the port not served last wins on a tie; rr pointer updates on grant.
  - Latch addr, write flag and wdata; pulse req_accept for the winner; go to ISSUE next cycle.
- ISSUE (1 cycle):
  - mem_address = {addr[ADDR_W-1:log2(BEATS)+2], beat, 2'b00}.
  - mem_read_or_write = write flag; mem_write_data = wdata slot[beat]; go to WAIT.
- WAIT:
  - Hold the memory outputs until done_evt.
  - On done_evt: if read, capture the word into slot[beat].
  - If beat == BEATS-1, go to RESP; otherwise beat+1 and go to ISSUE.
- RESP (1 cycle):
  - Pulse resp_valid for the granted port; resp_rdata is valid (holds the last read block until the next read completes).
  - Force mem_read_or_write = 0; clear beat; go to IDLE.
- Latency: 2 cycles per beat plus the memory delay, plus 2 cycles of overhead.
- Memory outputs never change inside WAIT. mem_read_or_write is 0 in IDLE, so no spurious writes occur.
- Requests arriving while busy are not accepted and wait. req_valid dropping after accept has no effect. A late done_evt in IDLE is ignored.
- Reset mid-transfer: immediate return to IDLE, no resp_valid, the partial block is discarded, mem_read_or_write drops to 0.
- Synchronizer flops also reset, so a pending done is dropped.

Decomposition:
- Shared package mem_arb_pkg:
  - State encoding (IDLE, ISSUE, WAIT, RESP).
  - Constants BLOCK_OFF_W = log2(BEATS)+2 and PORT_TLB = 0, PORT_CACHE = 1.
- One sub-module, pulse_sync_edge: 2-flop synchronizer plus rising-edge detector for mem_done, with async reset.

Test Plan:
- Port 1 block read at 0x100 → one req_accept[1] pulse, then 4 beats at mem_address 0x100, 0x104, 0x108, 0x10C → resp_valid[1] with resp_rdata = {0x11111111, 0x22222222, 0x33333333, 0x44444444} (beat3..beat0).
- Port 0 read at unaligned 0x10C → beats start at 0x100; same data as above; resp_valid[0] only.
- Port 1 block write at 0x200 with {0xD,0xC,0xB,0xA}, then a read at 0x200 → readback resp_rdata = {0xD,0xC,0xB,0xA}; mem_read_or_write = 1 only during the write beats.
- Both req_valid high in the same cycle:
  - RR_EN=0 → port 0 is served, then port 1.
  - RR_EN=1 with continuous requests → grants alternate 0,1,0,1.
- Reset asserted in WAIT of beat 2 → all outputs 0 asynchronously, no resp_valid. A fresh read at 0x040 afterwards returns {0xBBBBBBBB, 0x55555555, 0xEEEEEEEE, 0xCCCCCCCC}.
